d_strobe_tx: RTL and testbench
==============================

# d_strobe_tx

Transmit-side driver for the team's level-sensitive D-latch capture stage. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first onto a single data line `d_out`. Each bit is qualified by an enable strobe `en_out`, and the block guarantees latch setup and hold margins around every strobe. It sits between a word-producing controller and any downstream transparent-latch receiver.

## Interface
- `WIDTH`, 8: bits per word; must be ≥1.
- `SETUP`, 1: cycles `d_out` is stable with `en_out` low before each strobe rises; must be ≥1.
- `PULSE`, 2: cycles `en_out` is held high per bit; must be ≥1.
- `HOLD`, 1: cycles `d_out` is held with `en_out` low after each strobe falls; must be ≥1.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  WIDTH  word to transmit; sampled only on acceptance.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block can accept; equals (state == IDLE) and is combinational from state.
- `d_out`  out  1  serial data to latch D input; registered.
- `en_out`  out  1  latch enable strobe; registered, glitch-free.
- `busy`  out  1  high in every non-IDLE state; registered.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- A shift register holds the word. A bit index runs 0..WIDTH-1. One phase down-counter is sized `$clog2(max(SETUP,PULSE,HOLD)+1)`.
- IDLE:
  - `en_out`=0, `busy`=0, `in_ready`=1, `d_out` holds its last value.
  - On `in_valid & in_ready` at an edge: capture `in_data`, set `d_out` to bit 0, set bit index to 0, load the counter with SETUP, then go to SETUP.
- SETUP:
  - `en_out`=0 and `d_out` is stable.
  - When the counter expires: load PULSE, set `en_out` to 1, go to STROBE.
- STROBE:
  - `en_out`=1 and `d_out` is stable.
  - When the counter expires: load HOLD, set `en_out` to 0, go to HOLD.
- HOLD:
  - `en_out`=0 and `d_out` is stable.
  - When the counter expires and the bit index < WIDTH-1: increment the index, put the next bit on `d_out`, load SETUP, go to SETUP.
  - When the counter expires and the bit index == WIDTH-1: go to IDLE.
- `d_out` changes only on the IDLE→SETUP and HOLD→SETUP edges. It never changes while `en_out`=1, or in the same edge as an `en_out` transition.
- `in_valid` is ignored outside IDLE, and `in_data` is never resampled mid-word.
- Reset (`rst_n` low at any time, including mid-word):
  - Immediately forces `d_out`=0, `en_out`=0, `busy`=0 and state IDLE, so `in_ready`=1 after reset releases.
  - The in-flight word is discarded with no partial strobe extension.
  - Counter and index clear to 0.

## Timing
- Per-bit period is P = SETUP+PULSE+HOLD cycles. The word occupies WIDTH·P cycles after the acceptance edge.
- Acceptance edge at cycle k:
  - `d_out` = bit 0 and `busy`=1 from cycle k+1.
  - `en_out` rises at edge k+SETUP and stays high for exactly PULSE cycles.
- `in_ready` reasserts at the cycle after the last HOLD cycle. The minimum is one IDLE cycle between words, giving a back-to-back throughput of one word per WIDTH·P+1 cycles.
- Exactly WIDTH strobes per accepted word; `en_out` never rises in IDLE.

## Structure
- A shared package holds:
  - the state enum `dst_state_t` {IDLE, SETUP, STROBE, HOLD};
  - a `dst_cnt_w(setup, pulse, hold)` width function.
- One natural sub-module is `phase_timer`: a loadable down-counter with load value, load strobe and an `expired` output, reused for all three phases.
- The top-level module holds the FSM, the shift register and the bit index.

## Test plan
- WIDTH=4, SETUP=1, PULSE=2, HOLD=1; accept 4'b1010:
  - `d_out` sequence is 0,1,0,1, one bit per 4-cycle period;
  - four `en_out` pulses, each 2 cycles wide;
  - `busy` is high for 16 cycles, then `in_ready`=1.
- Checker across all scenarios: `d_out` is constant whenever `en_out`=1; `d_out` is stable for ≥SETUP cycles before every `en_out` rise and ≥HOLD cycles after every fall.
- `in_valid` held high with new `in_data`=8'hFF during a word (default params):
  - no acceptance until IDLE;
  - the original word is transmitted intact;
  - 8'hFF is accepted at the first `in_ready` edge.
- Assert `rst_n`=0 during the STROBE of bit 2:
  - `en_out` and `d_out` drop to 0 without waiting for a clock;
  - after release, `in_ready`=1 and no further strobes occur until a new accept.
- WIDTH=1, SETUP=PULSE=HOLD=1, with continuous `in_valid`:
  - a word is accepted every 4 cycles;
  - exactly one 1-cycle strobe per word.
- Connect `d_out`/`en_out` to a behavioural D latch and send random 16-word streams: the latch output, sampled at each `en_out` fall, reproduces every transmitted bit in order.

Source files
------------

// File: rtl/d_strobe_tx_pkg.sv
// -----------------------------------------------------------------------------
// d_strobe_tx_pkg
//
// Shared definitions for the D-latch strobe transmitter:
//   dst_state_t : FSM state encoding for d_strobe_tx.
//   dst_cnt_w() : width of the phase down-counter, which must be able to hold
//                 the largest of the three phase lengths.
// -----------------------------------------------------------------------------
package d_strobe_tx_pkg;

    // S_ prefix keeps the state names from colliding with the SETUP/HOLD
    // length parameters of the top module.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } dst_state_t;

    function automatic int dst_cnt_w(input int setup, input int pulse, input int hold);
        int m;
        m = setup;
        if (pulse > m) m = pulse;
        if (hold > m)  m = hold;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/d_strobe_tx_phase_timer.sv
// -----------------------------------------------------------------------------
// d_strobe_tx_phase_timer
//
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// Loading a value N makes the owning phase last exactly N cycles: the
// counter holds N in the first cycle of the phase and 'expired' is high in
// the last one (count == 1), so the FSM leaves the phase on that edge.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset, clears the count to 0
//   load      in   load load_val on the next edge (has priority over counting)
//   load_val  in   phase length in cycles, >= 1
//   expired   out  high during the final cycle of the loaded phase
// -----------------------------------------------------------------------------
module d_strobe_tx_phase_timer
    import d_strobe_tx_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    // Stops at zero so the counter idles quietly between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/d_strobe_tx.sv
// -----------------------------------------------------------------------------
// d_strobe_tx
//
// Transmit driver for a level-sensitive D-latch capture stage. A word taken
// over a valid/ready handshake is serialised LSB-first on d_out. Every bit is
// framed as SETUP cycles of data with en_out low, PULSE cycles with en_out
// high, and HOLD cycles of data with en_out low again, so the receiving latch
// always sees setup and hold margin around its enable.
//
// Parameters:
//   WIDTH  bits per word (>= 1)
//   SETUP  cycles d_out is stable before en_out rises (>= 1)
//   PULSE  cycles en_out is high per bit (>= 1)
//   HOLD   cycles d_out is held after en_out falls (>= 1)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset; aborts any word in flight
//   in_data   in   word to send, sampled only when accepted
//   in_valid  in   producer has a word
//   in_ready  out  high exactly in IDLE (combinational from state)
//   d_out     out  serial data to the latch D input (registered)
//   en_out    out  latch enable strobe (registered, glitch-free)
//   busy      out  high in every non-IDLE state (registered)
// -----------------------------------------------------------------------------
module d_strobe_tx
    import d_strobe_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d_out,
    output logic             en_out,
    output logic             busy
);

    localparam int CNT_W = dst_cnt_w(SETUP, PULSE, HOLD);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD);

    dst_state_t       state;
    dst_state_t       state_nxt;
    logic             d_nxt;
    logic             en_nxt;
    logic             busy_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;

    // shift_q holds the bits not yet driven onto d_out; bit 0 is the next one.
    logic [WIDTH-1:0] shift_q;
    logic             shift_load;
    logic             shift_adv;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expired;

    d_strobe_tx_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign in_ready = (state == S_IDLE);

    // Next-state and next-output logic. d_nxt only moves on the IDLE->SETUP
    // and HOLD->SETUP transitions, where en_out is low both before and after
    // the edge, so data never changes while the latch is transparent or on
    // an enable transition.
    always_comb begin
        state_nxt  = state;
        d_nxt      = d_out;
        en_nxt     = en_out;
        busy_nxt   = busy;
        idx_nxt    = idx;
        shift_load = 1'b0;
        shift_adv  = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt  = S_SETUP;
                    d_nxt      = in_data[0];
                    en_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    idx_nxt    = '0;
                    shift_load = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = LD_SETUP;
                end
            end

            S_SETUP: begin
                if (tmr_expired) begin
                    state_nxt = S_STROBE;
                    en_nxt    = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_PULSE;
                end
            end

            S_STROBE: begin
                if (tmr_expired) begin
                    state_nxt = S_HOLD;
                    en_nxt    = 1'b0;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_HOLD;
                end
            end

            S_HOLD: begin
                if (tmr_expired) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_SETUP;
                        d_nxt     = shift_q[0];
                        idx_nxt   = idx + IDX_W'(1);
                        shift_adv = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = LD_SETUP;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
                en_nxt    = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Control and output registers. Reset takes effect immediately, dropping
    // en_out mid-strobe rather than letting the pulse run to completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            d_out  <= 1'b0;
            en_out <= 1'b0;
            busy   <= 1'b0;
            idx    <= '0;
        end else begin
            state  <= state_nxt;
            d_out  <= d_nxt;
            en_out <= en_nxt;
            busy   <= busy_nxt;
            idx    <= idx_nxt;
        end
    end

    // Data path: bit 0 of the word goes straight to d_out on acceptance, so
    // the register keeps only the remaining bits.
    always_ff @(posedge clk) begin
        if (shift_load) begin
            shift_q <= in_data >> 1;
        end else if (shift_adv) begin
            shift_q <= shift_q >> 1;
        end
    end

endmodule

// File: tb/tb_d_strobe_tx.sv
module tb_d_strobe_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Instance A: WIDTH=4, SETUP=1, PULSE=2, HOLD=1
    logic [3:0] in_data_a;
    logic       in_valid_a, in_ready_a, d_a, en_a, busy_a;
    d_strobe_tx #(.WIDTH(4), .SETUP(1), .PULSE(2), .HOLD(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .d_out(d_a), .en_out(en_a), .busy(busy_a));

    // Instance B: default parameters (WIDTH=8, 1/2/1)
    logic [7:0] in_data_b;
    logic       in_valid_b, in_ready_b, d_b, en_b, busy_b;
    d_strobe_tx u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .d_out(d_b), .en_out(en_b), .busy(busy_b));

    // Instance C: WIDTH=1, SETUP=PULSE=HOLD=1
    logic [0:0] in_data_c;
    logic       in_valid_c, in_ready_c, d_c, en_c, busy_c;
    d_strobe_tx #(.WIDTH(1), .SETUP(1), .PULSE(1), .HOLD(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .d_out(d_c), .en_out(en_c), .busy(busy_c));

    // Behavioural transparent latch on instance B, sampled at each enable fall.
    logic q_b = 1'b0;
    always @* if (en_b) q_b = d_b;

    logic cap_on = 1'b0;
    bit   capq[$];
    always @(negedge en_b) if (rst_n && cap_on) capq.push_back(q_b);

    // Margin monitor over all three instances (all use SETUP=1, HOLD=1).
    localparam int SETUP_ALL = 1;
    localparam int HOLD_ALL  = 1;
    logic mon_d[3];
    logic mon_en[3];
    assign mon_d[0] = d_a;  assign mon_en[0] = en_a;
    assign mon_d[1] = d_b;  assign mon_en[1] = en_b;
    assign mon_d[2] = d_c;  assign mon_en[2] = en_c;

    logic prev_d[3]  = '{1'b0, 1'b0, 1'b0};
    logic prev_en[3] = '{1'b0, 1'b0, 1'b0};
    int   stable[3]  = '{100, 100, 100};
    int   age[3]     = '{0, 0, 0};
    int   viol       = 0;
    int   rises      = 0;
    logic chg;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                prev_d[i]  = 1'b0;
                prev_en[i] = 1'b0;
                stable[i]  = 100;
                age[i]     = 0;
            end else begin
                chg = (mon_d[i] !== prev_d[i]);
                if (!mon_en[i]) begin
                    if (prev_en[i]) age[i] = 1;
                    else if (age[i] != 0) age[i] = age[i] + 1;
                end
                if (chg && mon_en[i]) viol++;
                if (chg && !mon_en[i] && age[i] != 0 && age[i] < HOLD_ALL + 1) viol++;
                stable[i] = chg ? 1 : stable[i] + 1;
                if (mon_en[i] && !prev_en[i]) begin
                    rises++;
                    if (stable[i] < SETUP_ALL + 1) viol++;
                end
                prev_d[i]  = mon_d[i];
                prev_en[i] = mon_en[i];
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1;
        tests_run++;
        if ({in_ready_a, busy_a, en_a, d_a} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_a: got %b required %b", {in_ready_a, busy_a, en_a, d_a}, 4'b1000);
        end
        tests_run++;
        if ({in_ready_b, busy_b, en_b, d_b} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_b: got %b required %b", {in_ready_b, busy_b, en_b, d_b}, 4'b1000);
        end
        tests_run++;
        if ({in_ready_c, busy_c, en_c, d_c} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_c: got %b required %b", {in_ready_c, busy_c, en_c, d_c}, 4'b1000);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({in_ready_a, busy_a, en_a} !== 3'b100) begin
            tests_failed++;
            $display("FAIL reset_release_a: got %b required %b", {in_ready_a, busy_a, en_a}, 3'b100);
        end
    endtask

    // Accept 4'b1010 on A and check every cycle of the 16-cycle word.
    task automatic test_basic();
        logic [3:0] word;
        logic [3:0] exp;
        int         b, ph, pulses;
        logic       en_prev;
        word    = 4'b1010;
        pulses  = 0;
        en_prev = 1'b0;
        @(negedge clk);
        in_data_a  = word;
        in_valid_a = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            in_valid_a = 1'b0;
            if (j <= 16) begin
                b   = (j - 1) / 4;
                ph  = (j - 1) % 4;
                exp = {1'b0, 1'b1, (ph == 1 || ph == 2), word[b]};
            end else begin
                exp = {1'b1, 1'b0, 1'b0, word[3]};
            end
            tests_run++;
            if ({in_ready_a, busy_a, en_a, d_a} !== exp) begin
                tests_failed++;
                $display("FAIL basic_cycle%0d: got rdy/busy/en/d=%b required %b", j,
                         {in_ready_a, busy_a, en_a, d_a}, exp);
            end
            if (en_a && !en_prev) pulses++;
            en_prev = en_a;
        end
        tests_run++;
        if (pulses !== 4) begin
            tests_failed++;
            $display("FAIL basic_pulses: got %0d required %0d", pulses, 4);
        end
    endtask

    // Hold in_valid with 8'hFF while 8'h5A is in flight on B.
    task automatic test_ignore_valid();
        int         rdy_seen;
        logic [7:0] got;
        capq.delete();
        cap_on = 1'b1;
        @(negedge clk);
        in_data_b  = 8'h5A;
        in_valid_b = 1'b1;
        @(negedge clk);
        in_data_b = 8'hFF;
        tests_run++;
        if ({in_ready_b, busy_b, d_b} !== 3'b010) begin
            tests_failed++;
            $display("FAIL ignore_first: got rdy/busy/d=%b required %b", {in_ready_b, busy_b, d_b}, 3'b010);
        end
        rdy_seen = 0;
        for (int j = 2; j <= 32; j++) begin
            @(negedge clk);
            if (in_ready_b) rdy_seen++;
        end
        tests_run++;
        if (rdy_seen !== 0) begin
            tests_failed++;
            $display("FAIL ignore_no_accept: got %0d ready cycles required %0d", rdy_seen, 0);
        end
        @(negedge clk);
        tests_run++;
        if ({in_ready_b, busy_b, en_b, d_b} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ignore_idle: got %b required %b", {in_ready_b, busy_b, en_b, d_b}, 4'b1000);
        end
        @(negedge clk);
        in_valid_b = 1'b0;
        tests_run++;
        if ({in_ready_b, busy_b, d_b} !== 3'b011) begin
            tests_failed++;
            $display("FAIL ignore_ff_accept: got %b required %b", {in_ready_b, busy_b, d_b}, 3'b011);
        end
        got = 8'h00;
        for (int i = 0; i < 8; i++) if (i < capq.size()) got[i] = capq[i];
        tests_run++;
        if (got !== 8'h5A || capq.size() != 8) begin
            tests_failed++;
            $display("FAIL ignore_word1: got %h (%0d bits) required %h (8 bits)", got, capq.size(), 8'h5A);
        end
        repeat (32) @(negedge clk);
        got = 8'h00;
        for (int i = 0; i < 8; i++) if (i + 8 < capq.size()) got[i] = capq[i + 8];
        tests_run++;
        if (got !== 8'hFF || capq.size() != 16 || in_ready_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_word2: got %h (%0d bits, rdy %b) required %h (16 bits, rdy 1)",
                     got, capq.size(), in_ready_b, 8'hFF);
        end
        cap_on = 1'b0;
    endtask

    // Reset A asynchronously during the strobe of bit 2.
    task automatic test_reset_mid();
        int strobes, rdy_low;
        @(negedge clk);
        in_data_a  = 4'b0111;
        in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0;
        repeat (9) @(negedge clk);
        tests_run++;
        if ({en_a, d_a, busy_a} !== 3'b111) begin
            tests_failed++;
            $display("FAIL rstmid_pre: got en/d/busy=%b required %b", {en_a, d_a, busy_a}, 3'b111);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready_a, busy_a, en_a, d_a} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rstmid_async: got %b required %b", {in_ready_a, busy_a, en_a, d_a}, 4'b1000);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        strobes = 0;
        rdy_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (en_a) strobes++;
            if (!in_ready_a) rdy_low++;
        end
        tests_run++;
        if (strobes !== 0 || rdy_low !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_after: got %0d strobe and %0d not-ready cycles required 0 and 0",
                     strobes, rdy_low);
        end
    endtask

    // WIDTH=1 with in_valid held: one word every 4 cycles, one 1-cycle strobe each.
    task automatic test_back_to_back();
        logic [1:0] exp;
        logic       exp_d;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            exp = {(c % 4 == 0), (c % 4 == 2)};
            tests_run++;
            if ({in_ready_c, en_c} !== exp) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d: got rdy/en=%b required %b", c, {in_ready_c, en_c}, exp);
            end
            if (c % 4 != 0) begin
                exp_d = ((c >> 2) & 1) != 0;
                tests_run++;
                if (d_c !== exp_d) begin
                    tests_failed++;
                    $display("FAIL b2b_data%0d: got %b required %b", c, d_c, exp_d);
                end
            end
            in_data_c  = 1'(c >> 2);
            in_valid_c = 1'b1;
        end
        @(negedge clk);
        in_valid_c = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Sixteen random words through B into the behavioural latch.
    task automatic test_latch_stream();
        logic [7:0] words[16];
        logic [7:0] got;
        int         to;
        capq.delete();
        cap_on = 1'b1;
        for (int w = 0; w < 16; w++) begin
            words[w] = 8'($urandom);
            to = 0;
            @(negedge clk);
            while (!in_ready_b && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (to >= 100) begin
                tests_run++;
                tests_failed++;
                $display("FAIL stream_ready_timeout word%0d: got not-ready required ready within 100", w);
            end
            in_data_b  = words[w];
            in_valid_b = 1'b1;
            @(negedge clk);
            in_valid_b = 1'b0;
        end
        to = 0;
        while (!in_ready_b && to < 100) begin
            @(negedge clk);
            to++;
        end
        @(negedge clk);
        cap_on = 1'b0;
        tests_run++;
        if (capq.size() != 128) begin
            tests_failed++;
            $display("FAIL stream_bitcount: got %0d required %0d", capq.size(), 128);
        end
        for (int w = 0; w < 16; w++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) if (w * 8 + i < capq.size()) got[i] = capq[w * 8 + i];
            tests_run++;
            if (got !== words[w]) begin
                tests_failed++;
                $display("FAIL stream_word%0d: got %h required %h", w, got, words[w]);
            end
        end
    endtask

    task automatic test_margins();
        tests_run++;
        if (viol !== 0) begin
            tests_failed++;
            $display("FAIL margin_violations: got %0d required %0d", viol, 0);
        end
        // 4 (basic) + 3 (reset mid-word) + 16 + 128 (B) + 6 (C)
        tests_run++;
        if (rises !== 157) begin
            tests_failed++;
            $display("FAIL strobe_total: got %0d required %0d", rises, 157);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data_a  = '0;  in_valid_a = 1'b0;
        in_data_b  = '0;  in_valid_b = 1'b0;
        in_data_c  = '0;  in_valid_c = 1'b0;
        test_reset();
        test_basic();
        test_ignore_valid();
        test_reset_mid();
        test_back_to_back();
        test_latch_stream();
        test_margins();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
